// File: rtl/lenet_pool_pkg.sv
// Shared types and size helpers for the LeNet pooling data path.
package lenet_pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    // Output edge of a stride-2 pooling window.
    function automatic int calc_ifm_size_next(input int ifm_size, input int kernal_size);
        return (ifm_size - kernal_size) / 2 + 1;
    endfunction

    function automatic int calc_total(input int number_of_ifm, input int ifm_size_next);
        return number_of_ifm * ifm_size_next * ifm_size_next;
    endfunction

    localparam int DEFAULT_TOTAL = calc_total(2, calc_ifm_size_next(14, 2));

endpackage

// File: rtl/pool_wr_fifo.sv
// Small show-ahead FIFO between the pooling stage and the next-IFM memory.
// Head entry is visible combinationally whenever the FIFO is non-empty.
module pool_wr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]          wr_ptr_reg;
    logic [PTR_W:0]          rd_ptr_reg;
    logic [DATA_WIDTH-1:0]   entry [BUF_DEPTH];
    logic                    do_push;
    logic                    do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entry[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (do_push && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end

            assign entry[gi] = data_reg;
        end
    endgenerate

endmodule

// File: rtl/pool1_ofm_writer.sv
// Pool-1 output writer: buffers pooled pixels and writes them to the next-IFM
// memory with generated map/pixel addresses. Optional macro POOL1_OFM_WRITER_RELU_EN.
module pool1_ofm_writer
    import lenet_pool_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 14,
    parameter int KERNAL_SIZE           = 2,
    parameter int NUMBER_OF_IFM         = 2,
    parameter int IFM_SIZE_NEXT         = calc_ifm_size_next(IFM_SIZE, KERNAL_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int MAP_SEL_WIDTH         = (NUMBER_OF_IFM > 1) ? $clog2(NUMBER_OF_IFM) : 1,
    parameter int BUF_DEPTH             = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    input  logic                             mem_ready,
    output logic                             mem_we,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] mem_addr,
    output logic [MAP_SEL_WIDTH-1:0]         mem_map,
    output logic [DATA_WIDTH-1:0]            mem_data,
    output logic                             busy,
    output logic                             done,
    output logic                             ovf_err
);

    localparam int MAP_PIXELS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int TOTAL      = calc_total(NUMBER_OF_IFM, IFM_SIZE_NEXT);
    localparam int CNT_W      = $clog2(TOTAL + 1);

    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_NEXT_IFM'(MAP_PIXELS - 1);
    localparam logic [MAP_SEL_WIDTH-1:0]         LAST_MAP  = MAP_SEL_WIDTH'(NUMBER_OF_IFM - 1);
    localparam logic [CNT_W-1:0]                 LAST_BEAT = CNT_W'(TOTAL - 1);

    wr_state_t                        state_reg;
    wr_state_t                        state_next;
    logic [CNT_W-1:0]                 acc_cnt_reg;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] addr_reg;
    logic [MAP_SEL_WIDTH-1:0]         map_reg;
    logic                             ovf_reg;
    logic                             start_run;
    logic                             push;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             last_write;
    logic [DATA_WIDTH-1:0]            push_data;

`ifdef POOL1_OFM_WRITER_RELU_EN
    // Negative words (sign bit set) become zero; works for fixed and float.
    assign push_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign push_data = in_data;
`endif

    assign push       = in_valid && in_ready;
    assign mem_we     = !fifo_empty && mem_ready;
    assign last_write = mem_we && (addr_reg == LAST_ADDR) && (map_reg == LAST_MAP);
    assign mem_addr   = addr_reg;
    assign mem_map    = map_reg;
    assign ovf_err    = ovf_reg;

    pool_wr_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (mem_we),
        .push_data (push_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (mem_data)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_run  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = !fifo_full;
                if (push && (acc_cnt_reg == LAST_BEAT)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The final write is the only one that lands on the last map/pixel.
                busy = 1'b1;
                if (last_write) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            acc_cnt_reg <= '0;
            addr_reg    <= '0;
            map_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (start_run)  acc_cnt_reg <= '0;
            else if (push)  acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);

            if (start_run) begin
                addr_reg <= '0;
                map_reg  <= '0;
            end else if (mem_we) begin
                if (addr_reg == LAST_ADDR) begin
                    addr_reg <= '0;
                    map_reg  <= (map_reg == LAST_MAP) ? '0 : map_reg + MAP_SEL_WIDTH'(1);
                end else begin
                    addr_reg <= addr_reg + ADDRESS_SIZE_NEXT_IFM'(1);
                end
            end

            if (start_run) ovf_reg <= 1'b0;
            else if ((state_reg == ST_RUN) && in_valid && !in_ready) ovf_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pool1_ofm_writer.sv
// Scoreboard bench for pool1_ofm_writer: accepted beats feed an expected-write
// queue built from map/pixel arithmetic; a write monitor pops and compares.
module tb_pool1_ofm_writer;

    localparam int DW      = 32;
    localparam int MAP_PIX = 49;
    localparam int TOTAL   = 98;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_ready = 1'b1;
    logic          mem_we;
    logic [5:0]    mem_addr;
    logic [0:0]    mem_map;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          done;
    logic          ovf_err;

    pool1_ofm_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_map   (mem_map),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            map;
        int            addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_idx = 0;
    int   wr_cnt = 0;
    int   last_wr_cyc = -10;
    int   done_cnt = 0;
    bit   rand_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] model_data(input logic [DW-1:0] d);
`ifdef POOL1_OFM_WRITER_RELU_EN
        if (d[DW-1]) return '0;
`endif
        return d;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end

    // Stimulus side of the scoreboard: every accepted beat becomes one expected write.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            exp_t e;
            e.map  = acc_idx / MAP_PIX;
            e.addr = acc_idx % MAP_PIX;
            e.data = model_data(in_data);
            exp_q.push_back(e);
            acc_idx++;
        end
    end

    // Write monitor.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_addr), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("write map=%0d addr=%0d data=%h", mem_map, mem_addr, mem_data);
                chk("wr_map", 64'(mem_map), 64'(e.map));
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_data), 64'(e.data));
            end
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last_write", 64'(cyc - last_wr_cyc), 64'd1);
            chk("busy_low_with_done", 64'(busy), 64'd0);
        end
    end

    task automatic new_run();
        acc_idx = 0;
        wr_cnt  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap_max);
        int budget;
        int gap;
        gap = $urandom_range(0, gap_max);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        budget = 0;
        while (!in_ready && budget < 1000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 1000) begin
            chk("send_timeout", 64'(budget), 64'd0);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        int d0;
        t  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout", 64'(done_cnt - d0), 64'd1);
        chk("write_count", 64'(wr_cnt), 64'(TOTAL));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_mem_we"},   64'(mem_we),   64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_map"},  64'(mem_map),  64'd0);
        chk({tag, "_mem_data"}, 64'(mem_data), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_ovf_err"},  64'(ovf_err),  64'd0);
    endtask

    initial begin
        int d0;
        int t;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Streaming: data = beat index
        $display("scenario streaming");
        new_run();
        chk("busy_in_run", 64'(busy), 64'd1);
        for (int i = 0; i < TOTAL; i++) send(DW'(i), 0);
        wait_done();

        // Backpressure: memory stalled for 10 cycles while beats are offered
        $display("scenario backpressure");
        new_run();
        mem_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("bp_accepted", 64'(acc_idx), 64'd4);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_no_write", 64'(wr_cnt), 64'd0);
        mem_ready = 1'b1;
        while (acc_idx < TOTAL) send($urandom, 1);
        wait_done();
        chk("bp_no_ovf", 64'(ovf_err), 64'd0);

        // Overflow: beat forced while in_ready is low is dropped
        $display("scenario overflow");
        new_run();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, 0);
        chk("ovf_full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ovf_set", 64'(ovf_err), 64'd1);
        mem_ready = 1'b1;
        while (acc_idx < TOTAL) send($urandom, 0);
        wait_done();
        chk("ovf_sticky", 64'(ovf_err), 64'd1);

        // Start while busy is ignored; also ReLU test words first
        $display("scenario start_while_busy");
        new_run();
        chk("ovf_cleared_by_start", 64'(ovf_err), 64'd0);
        send(32'h8000_0010, 0);
        send(32'h0000_0010, 0);
        while (acc_idx < 40) send($urandom, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_stray_start", 64'(busy), 64'd1);
        while (acc_idx < TOTAL) send($urandom, 1);
        wait_done();

        // Reset mid-run after 30 writes
        $display("scenario reset_mid_run");
        new_run();
        for (int i = 0; i < 30; i++) send($urandom, 0);
        t = 0;
        while (wr_cnt < 30 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pre_reset_writes", 64'(wr_cnt), 64'd30);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        acc_idx = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        new_run();
        for (int i = 0; i < TOTAL; i++) send($urandom, 0);
        wait_done();

        // Randomized gaps and memory stalls
        $display("scenario random");
        new_run();
        rand_ready = 1;
        for (int i = 0; i < TOTAL; i++) send($urandom, 2);
        wait_done();
        rand_ready = 0;
        mem_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
